// File: rtl/uart_pkg.sv
// Shared UART package: arbiter state encoding and common constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE
  } arb_state_t;

  localparam int UART_DATA_W  = 8;
  localparam int ARB_BUSY_TMO = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART TX arbiter: per-requester byte, request, frame-end and grant/ack.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ-1:0]        last_i;
  logic [N_REQ-1:0]        ack_o;
  logic [N_REQ-1:0]        gnt_o;

  modport master (output req_i, data_i, last_i, input ack_o, gnt_o);
  modport slave  (input req_i, data_i, last_i, output ack_o, gnt_o);

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority one-hot picker: search starts at ptr+1 and wraps modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     oneHot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int k;

  always_comb begin
    oneHot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        oneHot[k] = 1'b1;
        idx       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uartTX between N_REQ byte producers.
// Optional frame lock is enabled by defining UART_ARB_LOCK_EN.
//
// state          | meaning
// ARB_IDLE       | waiting for tx idle and a pending request; grant latched on pick
// ARB_ISSUE      | pulse tx_wr_o/ack_o with the latched byte
// ARB_WAIT_BUSY  | waiting for uartTX to go busy (bounded by ARB_BUSY_TMO)
// ARB_WAIT_DONE  | waiting for uartTX to return idle, then rotate priority
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_tx_arbiter_if.slave  arb,
  output logic              tx_wr_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_rdy_i,
  output logic              busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = (ARB_BUSY_TMO > 1) ? $clog2(ARB_BUSY_TMO) : 1;

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ownerIdx;
  logic [N_REQ-1:0]  gntQ;
  logic [N_REQ-1:0]  ackQ;
  logic              txWrQ;
  logic [DATA_W-1:0] txDataQ;
  logic [DATA_W-1:0] byteQ;
  logic [TMO_W-1:0]  tmoCnt;
  logic              busyQ;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pickOh;
  logic [PTR_W-1:0]  pickIdx;
  logic              pickValid;

`ifdef UART_ARB_LOCK_EN
  logic lockedQ;
  logic lastQ;

  // While locked only the owner may continue its frame.
  always_comb begin
    eligible = arb.req_i;
    if (lockedQ) eligible = arb.req_i & gntQ;
  end
`else
  always_comb begin
    eligible = arb.req_i;
  end
`endif

  rr_pick #(.N(N_REQ), .IDX_W(PTR_W)) u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .oneHot (pickOh),
    .idx    (pickIdx),
    .valid  (pickValid)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ARB_IDLE;
      ptr      <= PTR_W'(N_REQ - 1);
      ownerIdx <= '0;
      gntQ     <= '0;
      ackQ     <= '0;
      txWrQ    <= 1'b0;
      txDataQ  <= '0;
      byteQ    <= '0;
      tmoCnt   <= '0;
      busyQ    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lockedQ  <= 1'b0;
      lastQ    <= 1'b0;
`endif
    end else begin
      txWrQ <= 1'b0;
      ackQ  <= '0;
      case (state)
        ARB_IDLE: begin
`ifdef UART_ARB_LOCK_EN
          if (lockedQ && !(|(arb.req_i & gntQ))) begin
            lockedQ <= 1'b0;
            gntQ    <= '0;
            ptr     <= ownerIdx;
          end else
`endif
          if (tx_rdy_i && pickValid) begin
            gntQ     <= pickOh;
            ownerIdx <= pickIdx;
            byteQ    <= arb.data_i[int'(pickIdx)*DATA_W +: DATA_W];
            busyQ    <= 1'b1;
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          txWrQ   <= 1'b1;
          txDataQ <= byteQ;
          ackQ    <= gntQ;
          tmoCnt  <= TMO_W'(ARB_BUSY_TMO - 1);
`ifdef UART_ARB_LOCK_EN
          lastQ   <= arb.last_i[ownerIdx];
`endif
          state   <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          // A uartTX that never drops rdy is assumed to have taken the byte.
          if (!tx_rdy_i || tmoCnt == '0) state <= ARB_WAIT_DONE;
          else                           tmoCnt <= tmoCnt - 1'b1;
        end
        ARB_WAIT_DONE: begin
          if (tx_rdy_i) begin
            busyQ <= 1'b0;
            state <= ARB_IDLE;
`ifdef UART_ARB_LOCK_EN
            if (lastQ) begin
              lockedQ <= 1'b0;
              gntQ    <= '0;
              ptr     <= ownerIdx;
            end else begin
              lockedQ <= 1'b1;
            end
`else
            gntQ <= '0;
            ptr  <= ownerIdx;
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign arb.ack_o = ackQ;
  assign arb.gnt_o = gntQ;
  assign tx_wr_o   = txWrQ;
  assign tx_data_o = txDataQ;
  assign busy_o    = busyQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uartTX busy model and a byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int FRAME = 10;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          txWr;
  logic [DW-1:0] txData;
  logic          txRdy;
  logic          busy;

  int total = 0;
  int bad   = 0;
  exp_t sbQ[$];

  int         mode = 0;   // 0: uartTX model, 1: rdy stuck 0, 2: rdy stuck 1
  logic       mdlRdy;
  int         mdlCnt;
  logic [7:0] mdlByte;

  int         cnt[NR];
  logic [7:0] base[NR];

  uart_tx_arbiter_if #(.N_REQ(NR), .DATA_W(DW)) arbBus ();

  uart_tx_arbiter #(.N_REQ(NR), .DATA_W(DW)) dut (
    .clk_i     (clk),
    .rst_i     (rstN),
    .arb       (arbBus),
    .tx_wr_o   (txWr),
    .tx_data_o (txData),
    .tx_rdy_i  (txRdy),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  assign txRdy = (mode == 0) ? mdlRdy : (mode == 2);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mdlRdy  <= 1'b1;
      mdlCnt  <= 0;
      mdlByte <= '0;
    end else if (txWr && mdlRdy) begin
      mdlRdy  <= 1'b0;
      mdlCnt  <= FRAME;
      mdlByte <= txData;
    end else if (!mdlRdy) begin
      if (mdlCnt <= 1) mdlRdy <= 1'b1;
      else             mdlCnt <= mdlCnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      check("gntOneHot", 32'($countones(arbBus.gnt_o) > 1), 0);
      if (txWr) begin
        if (sbQ.size() == 0) begin
          check("sbUnexpectedWr", {24'h0, txData}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          check("txData", txData, e.data);
          check("ackOnWr", arbBus.ack_o, 32'(1) << e.idx);
          check("gntOnWr", arbBus.gnt_o, 32'(1) << e.idx);
        end
      end else begin
        check("ackNoWr", arbBus.ack_o, 0);
      end
    end
  end

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sbQ.push_back(e);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    mode = 0;
    arbBus.req_i  = '0;
    arbBus.data_i = '0;
    arbBus.last_i = '1;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic waitWr(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!txWr && n < 60);
    check(tag, txWr, 1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((busy || !mdlRdy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, busy, 0);
    check({tag, "Sb"}, sbQ.size(), 0);
  endtask

  task automatic driveLane(input int k, input int sent, input bit frameLast);
    arbBus.data_i[k*DW +: DW] = base[k] + 8'(4 * sent);
    arbBus.last_i[k]          = frameLast ? (sent == cnt[k] - 1) : 1'b1;
  endtask

  task automatic runStream(input bit frameLast, input string tag);
    int  sent[NR];
    int  n;
    bit  done;
    for (int k = 0; k < NR; k++) begin
      sent[k] = 0;
      driveLane(k, 0, frameLast);
      arbBus.req_i[k] = (cnt[k] > 0);
    end
    n    = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      for (int k = 0; k < NR; k++) begin
        if (arbBus.ack_o[k]) begin
          sent[k]++;
          if (sent[k] >= cnt[k]) arbBus.req_i[k] = 1'b0;
          else                   driveLane(k, sent[k], frameLast);
        end
      end
      done = (arbBus.req_i == '0) && (sbQ.size() == 0) && !busy && mdlRdy;
    end
    check({tag, "Done"}, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    doReset();
    check("rstGnt", arbBus.gnt_o, 0);
    check("rstAck", arbBus.ack_o, 0);
    check("rstWr", txWr, 0);
    check("rstData", txData, 0);
    check("rstBusy", busy, 0);

    // single request, latency and serial byte
    push(2, 8'hA5);
    arbBus.data_i[2*DW +: DW] = 8'hA5;
    arbBus.req_i = 4'b0100;
    @(posedge clk); #1;
    check("t1WrEarly", txWr, 0);
    check("t1Gnt", arbBus.gnt_o, 4'b0100);
    @(posedge clk); #1;
    check("t1Lat2", txWr, 1);
    check("t1Ack", arbBus.ack_o, 4'b0100);
    arbBus.req_i = '0;
    waitIdle("t1Idle");
    check("t1Line", mdlByte, 8'hA5);

    // all four held: grant order 0,1,2,3,0
    doReset();
    cnt  = '{2, 1, 1, 1};
    base = '{8'h10, 8'h11, 8'h12, 8'h13};
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h14);
    runStream(1'b0, "t2");

    // requester 1 withdraws while the transmitter is busy
    doReset();
    mode = 1;
    arbBus.data_i[1*DW +: DW] = 8'h31;
    arbBus.data_i[3*DW +: DW] = 8'h33;
    arbBus.req_i = 4'b1010;
    repeat (3) @(posedge clk);
    #1 arbBus.req_i[1] = 1'b0;
    push(3, 8'h33);
    repeat (2) @(posedge clk);
    #1 mode = 0;
    waitWr("t3Wr");
    check("t3Gnt", arbBus.gnt_o, 4'b1000);
    arbBus.req_i = '0;
    waitIdle("t3Idle");

    // rdy low in IDLE, then stuck high after issue
    doReset();
    mode = 1;
    arbBus.data_i[0 +: DW] = 8'h44;
    arbBus.req_i = 4'b0001;
    push(0, 8'h44);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("t4NoWr", txWr, 0);
      check("t4NoGnt", arbBus.gnt_o, 0);
    end
    mode = 2;
    @(posedge clk); #1;
    check("t4GntAfterRdy", arbBus.gnt_o, 4'b0001);
    @(posedge clk); #1;
    check("t4Wr", txWr, 1);
    arbBus.req_i = '0;
    repeat (4) @(posedge clk);
    #1 check("t4TmoHold", busy, 1);
    @(posedge clk); #1;
    check("t4TmoIdle", busy, 0);
    check("t4Sb", sbQ.size(), 0);

    // reset mid-transfer, then priority restarts at requester 0
    doReset();
    arbBus.data_i[2*DW +: DW] = 8'h52;
    arbBus.req_i = 4'b0100;
    push(2, 8'h52);
    waitWr("t5Wr");
    arbBus.req_i = '0;
    repeat (4) @(posedge clk);
    check("t5PreBusy", busy, 1);
    check("t5PreRdy", mdlRdy, 0);
    #2 rstN = 1'b0;
    #1;
    check("t5RstGnt", arbBus.gnt_o, 0);
    check("t5RstBusy", busy, 0);
    check("t5RstData", txData, 0);
    check("t5RstWr", txWr, 0);
    check("t5RstAck", arbBus.ack_o, 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    for (int k = 0; k < NR; k++) arbBus.data_i[k*DW +: DW] = 8'h50 + 8'(k);
    arbBus.req_i = 4'b1101;
    push(0, 8'h50);
    waitWr("t5Wr2");
    arbBus.req_i = '0;
    waitIdle("t5Idle");

    // frame lock: requester 0 sends three bytes, requester 1 two
    doReset();
    cnt  = '{3, 2, 0, 0};
    base = '{8'h60, 8'h61, 8'h00, 8'h00};
`ifdef UART_ARB_LOCK_EN
    push(0, 8'h60); push(0, 8'h64); push(0, 8'h68); push(1, 8'h61); push(1, 8'h65);
`else
    push(0, 8'h60); push(1, 8'h61); push(0, 8'h64); push(1, 8'h65); push(0, 8'h68);
`endif
    runStream(1'b1, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
